// File: rtl/ppu_dot_seq.sv
// Posit dot-product sequencer driving a ppu_core_ops operand/op interface.
// Optional macro PPU_DOT_CORE_PIPE_EN: core has one registered output stage (2-cycle MUL/ADD).
module ppu_dot_seq #(
  parameter int unsigned          N       = 16,
  parameter int unsigned          ES      = 1,
  parameter int unsigned          OP_SIZE = 3,
  parameter logic [OP_SIZE-1:0]   MUL_OP  = OP_SIZE'(2),
  parameter logic [OP_SIZE-1:0]   ADD_OP  = OP_SIZE'(0),
  parameter int unsigned          LEN_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [LEN_W-1:0]   len,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N-1:0]       in_a,
  input  logic [N-1:0]       in_b,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [N-1:0]       res,
  output logic               busy,
  output logic [N-1:0]       core_p1,
  output logic [N-1:0]       core_p2,
  output logic [OP_SIZE-1:0] core_op,
  input  logic [N-1:0]       core_pout
);

  if (ES >= N) begin : g_es_chk
    $error("ES must be smaller than N");
  end

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MUL, S_ADD, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [N-1:0]       acc_q, acc_d, prod_q, prod_d, a_r_q, a_r_d, b_r_q, b_r_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d, len_r_q, len_r_d;
  logic               in_ready_q, in_ready_d, res_valid_q, res_valid_d, busy_q, busy_d;
  logic [N-1:0]       res_q, res_d, core_p1_q, core_p1_d, core_p2_q, core_p2_d;
  logic [OP_SIZE-1:0] core_op_q, core_op_d;
  logic               step_done;
`ifdef PPU_DOT_CORE_PIPE_EN
  logic               wait_q, wait_d;
`endif

  // Next state; outputs are registered from the next-state decode so they track the state.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    prod_d    = prod_q;
    a_r_d     = a_r_q;
    b_r_d     = b_r_q;
    cnt_d     = cnt_q;
    len_r_d   = len_r_q;
`ifdef PPU_DOT_CORE_PIPE_EN
    wait_d    = 1'b0;
    step_done = wait_q;
`else
    step_done = 1'b1;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          len_r_d = len;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = (len == '0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          a_r_d   = in_a;
          b_r_d   = in_b;
          state_d = S_MUL;
        end
      end
      S_MUL: begin
        if (step_done) begin
          prod_d  = core_pout;
          state_d = S_ADD;
        end
`ifdef PPU_DOT_CORE_PIPE_EN
        else begin
          wait_d = 1'b1;
        end
`endif
      end
      S_ADD: begin
        if (step_done) begin
          acc_d   = core_pout;
          cnt_d   = cnt_q + LEN_W'(1);
          state_d = (cnt_d == len_r_q) ? S_DONE : S_LOAD;
        end
`ifdef PPU_DOT_CORE_PIPE_EN
        else begin
          wait_d = 1'b1;
        end
`endif
      end
      S_DONE: begin
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    in_ready_d  = (state_d == S_LOAD);
    res_valid_d = (state_d == S_DONE);
    res_d       = res_valid_d ? acc_d : '0;
    busy_d      = (state_d != S_IDLE);
    core_p1_d   = '0;
    core_p2_d   = '0;
    core_op_d   = ADD_OP;
    if (state_d == S_MUL) begin
      core_p1_d = a_r_d;
      core_p2_d = b_r_d;
      core_op_d = MUL_OP;
    end else if (state_d == S_ADD) begin
      core_p1_d = acc_d;
      core_p2_d = prod_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      prod_q      <= '0;
      a_r_q       <= '0;
      b_r_q       <= '0;
      cnt_q       <= '0;
      len_r_q     <= '0;
      in_ready_q  <= 1'b0;
      res_valid_q <= 1'b0;
      res_q       <= '0;
      busy_q      <= 1'b0;
      core_p1_q   <= '0;
      core_p2_q   <= '0;
      core_op_q   <= ADD_OP;
`ifdef PPU_DOT_CORE_PIPE_EN
      wait_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      prod_q      <= prod_d;
      a_r_q       <= a_r_d;
      b_r_q       <= b_r_d;
      cnt_q       <= cnt_d;
      len_r_q     <= len_r_d;
      in_ready_q  <= in_ready_d;
      res_valid_q <= res_valid_d;
      res_q       <= res_d;
      busy_q      <= busy_d;
      core_p1_q   <= core_p1_d;
      core_p2_q   <= core_p2_d;
      core_op_q   <= core_op_d;
`ifdef PPU_DOT_CORE_PIPE_EN
      wait_q      <= wait_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign res_valid = res_valid_q;
  assign res       = res_q;
  assign busy      = busy_q;
  assign core_p1   = core_p1_q;
  assign core_p2   = core_p2_q;
  assign core_op   = core_op_q;

endmodule

// File: tb/tb_ppu_dot_seq.sv
// Self-checking bench for ppu_dot_seq with a real-arithmetic posit16/es1 core stub.
module tb_ppu_dot_seq;
  localparam int unsigned N = 16;
  localparam int unsigned OP_SIZE = 3;
  localparam int unsigned LEN_W = 8;
  localparam logic [2:0] MUL_OP = 3'd2;
  localparam logic [2:0] ADD_OP = 3'd0;
`ifdef PPU_DOT_CORE_PIPE_EN
  localparam int THR = 5, LAT = 4, STEP = 2;
`else
  localparam int THR = 3, LAT = 2, STEP = 1;
`endif

  logic clk, rst, start, in_valid, in_ready, res_valid, res_ready, busy;
  logic [LEN_W-1:0] len;
  logic [N-1:0] in_a, in_b, res, core_p1, core_p2, core_pout, core_f;
  logic [OP_SIZE-1:0] core_op;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [15:0] va [32];
  logic [15:0] vb [32];

  ppu_dot_seq #(.N(N), .ES(1), .OP_SIZE(OP_SIZE), .MUL_OP(MUL_OP), .ADD_OP(ADD_OP), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .res_valid(res_valid), .res_ready(res_ready), .res(res), .busy(busy),
    .core_p1(core_p1), .core_p2(core_p2), .core_op(core_op), .core_pout(core_pout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc <= cyc + 1;

  function automatic bit bit_at(input logic [15:0] v, input int i);
    return (i >= 0) && (((v >> i) & 16'd1) != 16'd0);
  endfunction

  // Posit16 es=1 value of a bit pattern (NaR handled by callers).
  function automatic real p2r(input logic [15:0] p);
    logic [15:0] v;
    int i, k, sc;
    real f, w, r;
    if (p == 16'h0000) return 0.0;
    v = p[15] ? 16'(-p) : p;
    i = 14;
    if (bit_at(v, 14)) begin
      k = -1;
      while (bit_at(v, i)) begin k++; i--; end
    end else begin
      k = 0;
      while (i >= 0 && !bit_at(v, i)) begin k--; i--; end
    end
    i--;
    sc = 2 * k + (bit_at(v, i) ? 1 : 0);
    i--;
    f = 1.0; w = 0.5;
    while (i >= 0) begin
      if (bit_at(v, i)) f = f + w;
      w = w / 2.0; i--;
    end
    r = f;
    if (sc >= 0) for (int j = 0; j < sc; j++) r = r * 2.0;
    else for (int j = 0; j < -sc; j++) r = r / 2.0;
    return p[15] ? -r : r;
  endfunction

  // Nearest posit to a real (ties to even pattern, no underflow to zero).
  function automatic logic [15:0] r2p(input real x);
    real ax, dl, dh;
    int lo, hi, mid;
    logic [15:0] q;
    if (x == 0.0) return 16'h0000;
    ax = (x < 0.0) ? -x : x;
    if (ax >= p2r(16'h7FFF)) q = 16'h7FFF;
    else if (ax <= p2r(16'h0001)) q = 16'h0001;
    else begin
      lo = 1; hi = 32767;
      while (hi - lo > 1) begin
        mid = (lo + hi) / 2;
        if (p2r(16'(mid)) <= ax) lo = mid; else hi = mid;
      end
      dl = ax - p2r(16'(lo));
      dh = p2r(16'(hi)) - ax;
      q = (dl < dh || (dl == dh && (lo % 2) == 0)) ? 16'(lo) : 16'(hi);
    end
    return (x < 0.0) ? 16'(-q) : q;
  endfunction

  function automatic logic [15:0] pmul(input logic [15:0] a, input logic [15:0] b);
    if (a == 16'h8000 || b == 16'h8000) return 16'h8000;
    return r2p(p2r(a) * p2r(b));
  endfunction

  function automatic logic [15:0] padd(input logic [15:0] a, input logic [15:0] b);
    if (a == 16'h8000 || b == 16'h8000) return 16'h8000;
    return r2p(p2r(a) + p2r(b));
  endfunction

  always_comb begin
    core_f = 16'h0000;
    if (core_op == MUL_OP) core_f = pmul(core_p1, core_p2);
    else if (core_op == ADD_OP) core_f = padd(core_p1, core_p2);
  end
`ifdef PPU_DOT_CORE_PIPE_EN
  always @(posedge clk) core_pout <= rst ? 16'h0000 : core_f;
`else
  assign core_pout = core_f;
`endif

  // Dot-product definition: acc = acc + a_i*b_i through the core ops.
  function automatic logic [15:0] ref_dot(input int n);
    logic [15:0] acc;
    acc = 16'h0000;
    for (int i = 0; i < n; i++) acc = padd(acc, pmul(va[i], vb[i]));
    return acc;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_res_valid"}, 32'(res_valid), 32'd0);
    chk({tag, "_res"}, 32'(res), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_core_p1"}, 32'(core_p1), 32'd0);
    chk({tag, "_core_p2"}, 32'(core_p2), 32'd0);
    chk({tag, "_core_op"}, 32'(core_op), 32'(ADD_OP));
  endtask

  // One full dot product over va/vb with optional input gaps, result backpressure and a stray start.
  task automatic run_dot(input int n, input int gap, input int hold, input bit poke, input logic [15:0] exp);
    int w, t_acc, t_prev;
    t_prev = 0;
    chk("idle_busy", 32'(busy), 32'd0);
    start = 1'b1; len = LEN_W'(n);
    tick();
    start = 1'b0;
    chk("start_busy", 32'(busy), 32'd1);
    if (n == 0) chk("len0_no_ready", 32'(in_ready), 32'd0);
    if (poke) begin
      start = 1'b1; len = LEN_W'(5);
      tick();
      start = 1'b0; len = '0;
    end
    for (int i = 0; i < n; i++) begin
      w = 0;
      while (!in_ready && w < 40) begin tick(); w++; end
      if (!in_ready) begin chk("in_ready_timeout", 32'(in_ready), 32'd1); return; end
      for (int g = 0; g < gap; g++) begin
        tick();
        chk("in_ready_hold", 32'(in_ready), 32'd1);
      end
      in_valid = 1'b1; in_a = va[i]; in_b = vb[i];
      tick();
      t_acc = cyc;
      in_valid = 1'b0; in_a = $urandom; in_b = $urandom;
      chk("in_ready_drop", 32'(in_ready), 32'd0);
      if (i > 0 && gap == 0) chk("throughput", 32'(t_acc - t_prev), 32'(THR));
      t_prev = t_acc;
    end
    w = 0;
    while (!res_valid && w < 40) begin tick(); w++; end
    if (n > 0) chk("latency", 32'(w), 32'(LAT));
    chk("res_valid", 32'(res_valid), 32'd1);
    chk("res", 32'(res), 32'(exp));
    for (int h = 0; h < hold; h++) begin
      tick();
      chk("hold_res_valid", 32'(res_valid), 32'd1);
      chk("hold_res", 32'(res), 32'(exp));
    end
    res_ready = 1'b1; start = 1'b1; len = LEN_W'(3);
    tick();
    res_ready = 1'b0; start = 1'b0;
    chk("release_res_valid", 32'(res_valid), 32'd0);
    chk("release_busy", 32'(busy), 32'd0);
    tick();
    chk("start_with_ready_ignored", 32'(busy), 32'd0);
  endtask

  typedef struct packed {
    logic [7:0]        n;
    logic [2:0][15:0]  a;
    logic [2:0][15:0]  b;
    logic [3:0]        gap;
    logic [3:0]        hold;
    logic [15:0]       exp;
  } vec_t;

  function automatic vec_t mk(input int n, input logic [15:0] a0, b0, a1, b1, a2, b2,
                              input int gap, input int hold, input logic [15:0] exp);
    vec_t v;
    v.n = 8'(n);
    v.a[0] = a0; v.b[0] = b0; v.a[1] = a1; v.b[1] = b1; v.a[2] = a2; v.b[2] = b2;
    v.gap = 4'(gap); v.hold = 4'(hold); v.exp = exp;
    return v;
  endfunction

  localparam int NV = 9;
  vec_t tbl [NV];

  initial begin
    int n, gap, hold;
    tbl[0] = mk(2, 16'h4000, 16'h5000, 16'h5000, 16'h5800, 16'h0, 16'h0, 0, 0, 16'h6800);
    tbl[1] = mk(0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 0, 0, 16'h0000);
    tbl[2] = mk(1, 16'h8000, 16'h4000, 16'h0, 16'h0, 16'h0, 16'h0, 0, 0, 16'h8000);
    tbl[3] = mk(1, 16'h3000, 16'h6000, 16'h0, 16'h0, 16'h0, 16'h0, 0, 0, 16'h5000);
    tbl[4] = mk(2, 16'h4000, 16'h5000, 16'h5000, 16'h5800, 16'h0, 16'h0, 5, 3, 16'h6800);
    tbl[5] = mk(3, 16'h4000, 16'h4000, 16'h4000, 16'h4000, 16'h4000, 16'h4000, 0, 1, 16'h5800);
    tbl[6] = mk(2, 16'hC000, 16'h5000, 16'h4000, 16'h5800, 16'h0, 16'h0, 1, 0, 16'h4000);
    tbl[7] = mk(2, 16'h0000, 16'h5000, 16'h4000, 16'h5000, 16'h0, 16'h0, 0, 0, 16'h5000);
    tbl[8] = mk(3, 16'h4000, 16'h4000, 16'h8000, 16'h0000, 16'h4000, 16'h4000, 2, 0, 16'h8000);

    rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0; in_a = '0; in_b = '0; res_ready = 1'b0;
    tick(); tick();
    chk_reset_outs("reset");
    rst = 1'b0;
    tick();
    chk_reset_outs("post_reset_idle");

    for (int t = 0; t < NV; t++) begin
      for (int i = 0; i < 3; i++) begin va[i] = tbl[t].a[i]; vb[i] = tbl[t].b[i]; end
      run_dot(int'(tbl[t].n), int'(tbl[t].gap), int'(tbl[t].hold), 1'b0, tbl[t].exp);
    end

    // Reset while in ADD of element 2 of 3.
    va[0] = 16'h4000; vb[0] = 16'h5000; va[1] = 16'h5000; vb[1] = 16'h5800;
    start = 1'b1; len = LEN_W'(3);
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      int w;
      w = 0;
      while (!in_ready && w < 40) begin tick(); w++; end
      chk("abort_in_ready", 32'(in_ready), 32'd1);
      in_valid = 1'b1; in_a = va[i]; in_b = vb[i];
      tick();
      in_valid = 1'b0;
    end
    repeat (STEP) tick();
    chk("abort_add_op", 32'(core_op), 32'(ADD_OP));
    chk("abort_add_p1", 32'(core_p1), 32'h5000);
    chk("abort_add_p2", 32'(core_p2), 32'h6400);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset_outs("abort");
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("abort_no_result", 32'(res_valid), 32'd0);
    end
    va[0] = 16'h4000; vb[0] = 16'h4000;
    run_dot(1, 0, 0, 1'b0, 16'h4000);

    // Stray start with len=5 during LOAD must not disturb a len=2 run.
    va[0] = 16'h4000; vb[0] = 16'h5000; va[1] = 16'h5000; vb[1] = 16'h5800;
    run_dot(2, 0, 0, 1'b1, 16'h6800);

    // Random vectors against the dot-product reference.
    for (int r = 0; r < 8; r++) begin
      n = int'($urandom_range(1, 10));
      gap = int'($urandom_range(0, 2));
      hold = int'($urandom_range(0, 2));
      for (int i = 0; i < n; i++) begin
        va[i] = 16'($urandom);
        vb[i] = 16'($urandom);
        if ($urandom_range(0, 15) == 0) va[i] = 16'h8000;
      end
      run_dot(n, gap, hold, 1'b0, ref_dot(n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
